// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants and state type for the mux scan controller
package mux_scan_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/mux_scan_controller_if.sv
// rtl/mux_scan_controller_if.sv - control/select/snapshot bundle between scanner and its user/mux
interface mux_scan_if;
  import mux_scan_pkg::*;

  logic             start;
  logic             cont;
  logic [N_CH-1:0]  mask;
  logic             mux_out;
  logic [SEL_W-1:0] S;
  logic [N_CH-1:0]  sample;
  logic             valid;
  logic             busy;

  modport slave  (input  start, cont, mask, mux_out,
                  output S, sample, valid, busy);
  modport master (output start, cont, mask, mux_out,
                  input  S, sample, valid, busy);
endinterface

// File: rtl/mux_next_channel.sv
// rtl/mux_next_channel.sv - next higher enabled channel above i_cur (or lowest, with i_from_below)
module mux_next_channel
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  i_mask,
  input  logic [SEL_W-1:0] i_cur,
  input  logic             i_from_below,
  output logic [SEL_W-1:0] o_next,
  output logic             o_last
);
  // Descending walk so the lowest qualifying channel is the one left standing.
  always_comb begin
    o_next = i_cur;
    o_last = 1'b1;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_mask[k] && (i_from_below || (SEL_W'(k) > i_cur))) begin
        o_next = SEL_W'(k);
        o_last = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux_scan_controller.sv
// rtl/mux_scan_controller.sv - steps the 4:1 mux select over enabled channels and
// captures one bit per channel after a programmable dwell, emitting a 4-bit snapshot.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_CH-1:0]  r_mask, w_mask_nxt;
  logic [N_CH-1:0]  r_shadow, w_shadow_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [N_CH-1:0]  r_sample, w_sample_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;

  logic [SEL_W-1:0] w_next_sel, w_first_sel;
  logic             w_last, w_first_none;
  logic             w_capture;
  logic [N_CH-1:0]  w_shadow_cap;

  mux_next_channel u_next (
    .i_mask       (r_mask),
    .i_cur        (r_sel),
    .i_from_below (1'b0),
    .o_next       (w_next_sel),
    .o_last       (w_last)
  );

  // Looks at the live mask input: used both for a fresh start and a continuous relatch.
  mux_next_channel u_first (
    .i_mask       (bus.mask),
    .i_cur        ('0),
    .i_from_below (1'b1),
    .o_next       (w_first_sel),
    .o_last       (w_first_none)
  );

  assign w_capture = (r_state == SCAN) && (r_cnt == CNT_W'(DWELL - 1));

  always_comb begin
    w_shadow_cap        = r_shadow;
    w_shadow_cap[r_sel] = bus.mux_out;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_shadow_nxt = r_shadow;
    w_sel_nxt    = r_sel;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (bus.start && !w_first_none) begin
          w_mask_nxt   = bus.mask;
          w_sel_nxt    = w_first_sel;
          w_cnt_nxt    = '0;
          w_shadow_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (!w_capture) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt    = '0;
          w_shadow_nxt = w_shadow_cap;
          if (!w_last) begin
            w_sel_nxt = w_next_sel;
          end else begin
            w_sample_nxt = w_shadow_cap & r_mask;
            w_valid_nxt  = 1'b1;
            if (bus.cont && !w_first_none) begin
              w_mask_nxt   = bus.mask;
              w_sel_nxt    = w_first_sel;
              w_shadow_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_sel    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_sel    <= w_sel_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.S      = r_sel;
  assign bus.sample = r_sample;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_mux_scan_controller.sv
// tb/tb_mux_scan_controller.sv - directed bench over four dwell settings of mux_scan_controller
module tb_mux_scan_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] r_i4 = 4'b0, r_i2 = 4'b0, r_i3 = 4'b0, r_i1 = 4'b0;

  mux_scan_if if4 ();
  mux_scan_if if2 ();
  mux_scan_if if3 ();
  mux_scan_if if1 ();

  assign if4.mux_out = r_i4[if4.S];
  assign if2.mux_out = r_i2[if2.S];
  assign if3.mux_out = r_i3[if3.S];
  assign if1.mux_out = r_i1[if1.S];

  mux_scan_controller #(.DWELL(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  mux_scan_controller #(.DWELL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mux_scan_controller #(.DWELL(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  mux_scan_controller #(.DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    if4.start = 0; if4.cont = 0; if4.mask = 0;
    if2.start = 0; if2.cont = 0; if2.mask = 0;
    if3.start = 0; if3.cont = 0; if3.mask = 0;
    if1.start = 0; if1.cont = 0; if1.mask = 0;
    tick(2);
    check("rst_S", 8'(if4.S), 8'd0);
    check("rst_sample", 8'(if4.sample), 8'd0);
    check("rst_valid", 8'(if4.valid), 8'd0);
    check("rst_busy", 8'(if4.busy), 8'd0);
    rst_n = 1'b1;
    tick(1);

    // Full mask, DWELL=4, I=1010; a start/mask glitch mid-scan must be ignored
    r_i4 = 4'b1010; if4.mask = 4'hF; if4.start = 1;
    tick(1); if4.start = 0;
    check("d4_first_S", 8'(if4.S), 8'd0);
    check("d4_first_busy", 8'(if4.busy), 8'd1);
    if4.start = 1; if4.mask = 4'h0;
    tick(1); if4.start = 0;
    tick(2);
    check("d4_S_hold", 8'(if4.S), 8'd0);
    tick(1);
    check("d4_S1", 8'(if4.S), 8'd1);
    tick(4);
    check("d4_S2", 8'(if4.S), 8'd2);
    tick(4);
    check("d4_S3", 8'(if4.S), 8'd3);
    tick(3);
    check("d4_valid_early", 8'(if4.valid), 8'd0);
    check("d4_busy_early", 8'(if4.busy), 8'd1);
    tick(1);
    check("d4_valid", 8'(if4.valid), 8'd1);
    check("d4_sample", 8'(if4.sample), 8'hA);
    check("d4_busy_fall", 8'(if4.busy), 8'd0);
    check("d4_S_hold_last", 8'(if4.S), 8'd3);
    tick(1);
    check("d4_valid_pulse", 8'(if4.valid), 8'd0);

    // DWELL=2: zero mask start is ignored, then mask 0101
    if2.mask = 4'h0; if2.start = 1;
    tick(1); if2.start = 0;
    check("d2_zero_busy", 8'(if2.busy), 8'd0);
    tick(3);
    check("d2_zero_valid", 8'(if2.valid), 8'd0);
    r_i2 = 4'hF; if2.mask = 4'b0101; if2.start = 1;
    tick(1); if2.start = 0;
    check("d2_first_S", 8'(if2.S), 8'd0);
    check("d2_busy", 8'(if2.busy), 8'd1);
    tick(2);
    check("d2_S2", 8'(if2.S), 8'd2);
    tick(1);
    check("d2_valid_early", 8'(if2.valid), 8'd0);
    tick(1);
    check("d2_valid", 8'(if2.valid), 8'd1);
    check("d2_sample", 8'(if2.sample), 8'h5);
    check("d2_busy_fall", 8'(if2.busy), 8'd0);

    // DWELL=3 continuous, single channel 3
    r_i3 = 4'b1000; if3.cont = 1; if3.mask = 4'b1000; if3.start = 1;
    tick(1); if3.start = 0;
    check("d3_first_S", 8'(if3.S), 8'd3);
    check("d3_busy", 8'(if3.busy), 8'd1);
    tick(2);
    check("d3_valid_early", 8'(if3.valid), 8'd0);
    tick(1);
    check("d3_valid1", 8'(if3.valid), 8'd1);
    check("d3_sample1", 8'(if3.sample), 8'h8);
    check("d3_busy1", 8'(if3.busy), 8'd1);
    r_i3 = 4'b0000;
    tick(1);
    check("d3_valid_gap", 8'(if3.valid), 8'd0);
    check("d3_busy_gap", 8'(if3.busy), 8'd1);
    tick(2);
    check("d3_valid2", 8'(if3.valid), 8'd1);
    check("d3_sample2", 8'(if3.sample), 8'h0);
    check("d3_busy2", 8'(if3.busy), 8'd1);
    if3.mask = 4'h0; r_i3 = 4'b1000;
    tick(3);
    check("d3_valid3", 8'(if3.valid), 8'd1);
    check("d3_sample3", 8'(if3.sample), 8'h8);
    check("d3_busy3", 8'(if3.busy), 8'd0);
    tick(1);
    check("d3_idle_valid", 8'(if3.valid), 8'd0);
    check("d3_idle_busy", 8'(if3.busy), 8'd0);
    if3.cont = 0;

    // DWELL=1 full mask
    r_i1 = 4'b0110; if1.mask = 4'hF; if1.start = 1;
    tick(1); if1.start = 0;
    check("d1_first_S", 8'(if1.S), 8'd0);
    check("d1_busy", 8'(if1.busy), 8'd1);
    tick(3);
    check("d1_S3", 8'(if1.S), 8'd3);
    check("d1_valid_early", 8'(if1.valid), 8'd0);
    tick(1);
    check("d1_valid", 8'(if1.valid), 8'd1);
    check("d1_sample", 8'(if1.sample), 8'h6);
    check("d1_busy_fall", 8'(if1.busy), 8'd0);

    // Asynchronous reset at the second capture of a full-mask scan
    r_i4 = 4'b1010; if4.mask = 4'hF; if4.start = 1;
    tick(1); if4.start = 0;
    tick(8);
    check("rs_S_before", 8'(if4.S), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rs_S", 8'(if4.S), 8'd0);
    check("rs_sample", 8'(if4.sample), 8'd0);
    check("rs_valid", 8'(if4.valid), 8'd0);
    check("rs_busy", 8'(if4.busy), 8'd0);
    tick(2);
    rst_n = 1'b1; r_i4 = 4'b0101; if4.mask = 4'hF; if4.start = 1;
    tick(1); if4.start = 0;
    check("rs_restart_S", 8'(if4.S), 8'd0);
    check("rs_restart_busy", 8'(if4.busy), 8'd1);
    tick(15);
    check("rs_valid_early", 8'(if4.valid), 8'd0);
    tick(1);
    check("rs_valid", 8'(if4.valid), 8'd1);
    check("rs_sample_new", 8'(if4.sample), 8'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_scan_controller.md
# mux_scan_controller

Sequencer that drives the select lines of the 4-to-1 multiplexer and consumes its output. On a start request it steps the select through every enabled input channel, holds each selection for a programmable dwell time, and samples the multiplexer output at the end of each dwell. It then presents all captured bits as one 4-bit snapshot with a single-cycle valid strobe. It sits directly around the mux: S feeds the mux select, and the mux output returns on `mux_out`.

## Interface
- `DWELL`, default 4: cycles each channel is held selected before sampling; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: scan request, sampled each cycle; honoured only in IDLE.
- `cont` input 1: continuous mode; sampled at the final capture edge of a scan.
- `mask` input 4: channel enable, with bit k enabling channel k; latched when a scan begins.
- `mux_out` input 1: multiplexer output returning from the selected channel.
- `S` output 2: multiplexer select (registered).
- `sample` output 4: last completed snapshot; bit k holds channel k's captured value; masked channels read 0.
- `valid` output 1: one-cycle strobe when `sample` updates.
- `busy` output 1: high while a scan is in progress.

## Operation
- States:
  - IDLE: waits for a request.
  - SCAN: dwelling on or sampling channels.
- Reset values, applied asynchronously: state IDLE, `S`=0, `sample`=0, `valid`=0, `busy`=0, dwell count 0, latched mask 0, shadow register 0.
- Scan start (IDLE, `start`=1, `mask`≠0):
  - Latch `mask`.
  - Set `S` to the lowest enabled channel.
  - Set dwell count to 0, clear shadow, set `busy`=1, enter SCAN.
- `start`=1 with `mask`=0 in IDLE: ignored, stays IDLE, no valid.
- `start` while `busy`: ignored; `mask` changes mid-scan have no effect.
- SCAN, each cycle: the dwell count increments until it reaches DWELL-1.
- Capture edge (count = DWELL-1):
  - Write `mux_out` into shadow bit `S`.
  - Reset the count to 0.
  - Move `S` to the next higher enabled channel in the latched mask.
- Last enabled channel captured:
  - Load `sample` from shadow including this capture; disabled bits are 0.
  - Assert `valid` for exactly one cycle.
- Then, based on `cont`:
  - `cont`=0: go to IDLE, `busy`=0, `S` holds the last channel.
  - `cont`=1: relatch `mask`. If it is nonzero, start the next scan immediately at its lowest enabled channel with `busy` held high. If it is zero, go to IDLE.
- Select ordering is ascending; channels are never revisited within one scan, and there is no wrap within a scan.
- `valid` never asserts from IDLE without a completed scan.

## Timing
- `start` is accepted on edge E. `S` shows the first enabled channel and `busy`=1 in the cycle after E.
- With n enabled channels, capture edges fall at E+DWELL, E+2·DWELL, …, E+n·DWELL.
- `valid`=1 and the new `sample` appear in the cycle after edge E+n·DWELL, so latency is n·DWELL cycles.
- `busy` falls in the same cycle `valid` rises when `cont`=0.
- `mux_out` is treated as settled one combinational path after `S`. With DWELL=1 it is sampled in the first cycle after the select changes.
- Continuous mode: consecutive scans are back-to-back with no idle cycle; the next scan's first capture is DWELL cycles after the previous valid edge.
- Reset asserted mid-scan: the scan is abandoned, all outputs return to reset values immediately, and no valid is issued.
- The first `start` is honoured on the first edge after `rst_n` deasserts.

## Structure
- Shared package `mux_scan_pkg`:
  - `N_CH`=4 and `SEL_W`=2.
  - State enum {IDLE, SCAN}.
  - Dwell counter width of 8.
- Sub-module `mux_next_channel` (combinational): takes the latched mask and current select, returns the next higher enabled index and a `last` flag. It also serves, with a "from below 0" input, to find the lowest enabled channel.
- Top level holds the FSM, dwell counter, shadow register and output registers.

## Test plan
- Full mask, DWELL=4, `mux_out` driven as I[S] with I=4'b1010: start at edge E → S steps 0,1,2,3 every 4 cycles; valid high in the cycle after E+16; `sample`=4'b1010, `busy` low the same cycle.
- mask=4'b0101, DWELL=2, I=4'b1111: S visits 0 then 2 only; valid at E+4; `sample`=4'b0101.
- `cont`=1, mask=4'b1000, DWELL=3, I toggles between scans: valid every 3 cycles with `busy` staying high; mask changed to 0 mid-scan → the scan completes, then IDLE.
- `start` with mask=0, then `start` pulses during a busy scan → no valid from either, and the ongoing scan's timing is unchanged.
- `rst_n` pulled low at the second capture of a full-mask scan → `S`=0, `sample`=0, `valid`=0, `busy`=0 asynchronously; a new start after release produces a correct snapshot.
- DWELL=1, full mask, I=4'b0110 → valid at E+4, `sample`=4'b0110.
